// File: rtl/spi_frame_loader_pkg.sv
// Shared types and width helpers for the SPI frame loader.
// The frame typedef below describes the default 8-bit x 128 configuration;
// parametrised instances build their own frame shape from DATA_W/NUM_SAMPLES.
package spi_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Index width for a frame of num_samples words (never narrower than 1 bit)
   function automatic int idx_width(input int num_samples);
      return (num_samples > 1) ? $clog2(num_samples) : 1;
   endfunction

   // Bit-counter width for a word of data_w bits (never narrower than 1 bit)
   function automatic int bit_width(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

   localparam int DEFAULT_DATA_W      = 8;
   localparam int DEFAULT_NUM_SAMPLES = 128;
   localparam int IDX_W               = idx_width(DEFAULT_NUM_SAMPLES);
   localparam int BIT_W               = bit_width(DEFAULT_DATA_W);

   typedef logic [0:DEFAULT_NUM_SAMPLES-1][DEFAULT_DATA_W-1:0] frame_t;

endpackage

// File: rtl/spi_frame_loader_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a one-cycle pulse
// on each rising edge of the synchronised level. RESET_VAL sets the idle
// level the chain holds in reset (1 for active-low selects).
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   delay_q;

   // Shift the pin through the chain; delay_q remembers last synced level
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q  <= {SYNC_STAGES{RESET_VAL}};
         delay_q <= RESET_VAL;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
         delay_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~delay_q;

endmodule

// File: rtl/spi_frame_loader.sv
// SPI-slave sample loader: deserialises MSB-first words from the SPI pins
// into a frame of NUM_SAMPLES words and hands it to the FFT core through a
// frame_valid/frame_ack handshake, flagging dropped words on overrun.
// Build option: define SPI_LOADER_DBUF_EN for ping-pong buffering (capture
// continues into a second bank while the completed frame is presented).
module spi_frame_loader
   import spi_loader_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int NUM_SAMPLES = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               n_rst,
   input  logic                               clk_in,
   input  logic                               ss,
   input  logic                               data_in,
   output logic [0:NUM_SAMPLES-1][DATA_W-1:0] frame_out,
   output logic                               frame_valid,
   input  logic                               frame_ack,
   output logic                               overrun,
   output logic [idx_width(NUM_SAMPLES)-1:0]  word_idx
);

   localparam int IDX_BITS = idx_width(NUM_SAMPLES);
   localparam int CNT_BITS = bit_width(DATA_W);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SAMPLES - 1);
   localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(DATA_W - 1);

   logic sclk_rise;
   logic sclk_level_unused;
   logic ss_s;
   logic ss_rise_unused;
   logic din_s;
   logic din_rise_unused;

   state_t              state_q;
   logic [DATA_W-1:0]   shift_q;
   logic [CNT_BITS-1:0] bit_cnt_q;
   logic [DATA_W-1:0]   next_word;
   logic                capture;
   logic                word_done;
   logic                last_word;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (clk_in),
      .sync_out (sclk_level_unused),
      .rise     (sclk_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (ss),
      .sync_out (ss_s),
      .rise     (ss_rise_unused)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (data_in),
      .sync_out (din_s),
      .rise     (din_rise_unused)
   );

   assign next_word = {shift_q[DATA_W-2:0], din_s};
   assign capture   = sclk_rise & ~ss_s & (state_q != IDLE);
   assign word_done = capture & (bit_cnt_q == LAST_BIT);
   assign last_word = (word_idx == LAST_IDX);

   // Serial shifter: bits keep arriving in FULL too so a late word can be detected
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (ss_s) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (capture) begin
         shift_q   <= next_word;
         bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_BITS'(1);
      end
   end

`ifdef SPI_LOADER_DBUF_EN

   logic [0:NUM_SAMPLES-1][DATA_W-1:0] cap_q;
   logic [0:NUM_SAMPLES-1][DATA_W-1:0] filled_frame;

   // Capture bank with the final word merged in, ready to become frame_out
   always_comb begin
      filled_frame                = cap_q;
      filled_frame[NUM_SAMPLES-1] = next_word;
   end

   // Ping-pong frame FSM: capture never stalls, an unacked frame blocks the next one
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         word_idx    <= '0;
         cap_q       <= '0;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (frame_valid && frame_ack) begin
            frame_valid <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               word_idx <= '0;
               if (!ss_s) begin
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (ss_s) begin
                  state_q  <= IDLE;
                  word_idx <= '0;
               end else if (word_done) begin
                  if (!last_word) begin
                     cap_q[word_idx] <= next_word;
                     word_idx        <= word_idx + IDX_BITS'(1);
                  end else begin
                     word_idx <= '0;
                     if (frame_valid && !frame_ack) begin
                        overrun <= 1'b1;
                     end else begin
                        frame_out   <= filled_frame;
                        frame_valid <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_q  <= IDLE;
               word_idx <= '0;
            end
         endcase
      end
   end

`else

   // Single-bank frame FSM: a completed frame freezes capture until acked
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         word_idx    <= '0;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               word_idx <= '0;
               if (!ss_s) begin
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (ss_s) begin
                  state_q  <= IDLE;
                  word_idx <= '0;
               end else if (word_done) begin
                  frame_out[word_idx] <= next_word;
                  if (last_word) begin
                     word_idx    <= '0;
                     frame_valid <= 1'b1;
                     state_q     <= FULL;
                  end else begin
                     word_idx <= word_idx + IDX_BITS'(1);
                  end
               end
            end
            FULL: begin
               if (frame_ack) begin
                  frame_valid <= 1'b0;
                  state_q     <= ss_s ? IDLE : SHIFT;
                  if (word_done) begin
                     frame_out[0] <= next_word;
                     word_idx     <= IDX_BITS'(1);
                  end
               end else if (word_done) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               word_idx <= '0;
            end
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: a default 8x128 instance and a
// 12x4 instance share the SPI clock/data pins and have their own selects.
// Covers both the single-bank build and SPI_LOADER_DBUF_EN.
module tb_spi_frame_loader;

   logic clk;
   logic n_rst;
   logic sclk;
   logic mosi;
   logic ss8;
   logic ss12;
   logic ack8;
   logic ack12;

   logic [0:127][7:0] f8;
   logic              valid8;
   logic              ovr8;
   logic [6:0]        widx8;

   logic [0:3][11:0]  f12;
   logic              valid12;
   logic              ovr12;
   logic [1:0]        widx12;

   int vectors;
   int miscompares;

   typedef struct {
      logic [11:0] word;
      logic [1:0]  exp_idx;
      logic        exp_valid;
   } vec12_t;

   vec12_t vec12 [4];

   spi_frame_loader dut8 (
      .clk         (clk),
      .n_rst       (n_rst),
      .clk_in      (sclk),
      .ss          (ss8),
      .data_in     (mosi),
      .frame_out   (f8),
      .frame_valid (valid8),
      .frame_ack   (ack8),
      .overrun     (ovr8),
      .word_idx    (widx8)
   );

   spi_frame_loader #(.DATA_W(12), .NUM_SAMPLES(4), .SYNC_STAGES(2)) dut12 (
      .clk         (clk),
      .n_rst       (n_rst),
      .clk_in      (sclk),
      .ss          (ss12),
      .data_in     (mosi),
      .frame_out   (f12),
      .frame_valid (valid12),
      .frame_ack   (ack12),
      .overrun     (ovr12),
      .word_idx    (widx12)
   );

   // System clock, 10 ns period; SPI bits take 6 system clocks
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Shift nbits of word MSB first; optionally pulse ack8 exactly on the capture edge of the last bit
   task automatic applyStimulus(input int nbits, input logic [15:0] word, input logic ack_last);
      for (int b = nbits - 1; b >= 0; b--) begin
         mosi = word[b];
         sclk = 1'b0;
         repeat (3) @(negedge clk);
         sclk = 1'b1;
         if (ack_last && b == 0) begin
            repeat (2) @(negedge clk);
            ack8 = 1'b1;
            @(negedge clk);
            ack8 = 1'b0;
         end else begin
            repeat (3) @(negedge clk);
         end
      end
      sclk = 1'b0;
   endtask

   // Single-cycle ack pulse to the 8-bit instance
   task automatic pulseAck8();
      ack8 = 1'b1;
      @(negedge clk);
      ack8 = 1'b0;
   endtask

   // Main directed sequence
   initial begin
      int errs;
      vectors     = 0;
      miscompares = 0;

      vec12[0] = '{word: 12'hABC, exp_idx: 2'd1, exp_valid: 1'b0};
      vec12[1] = '{word: 12'h123, exp_idx: 2'd2, exp_valid: 1'b0};
      vec12[2] = '{word: 12'hFFF, exp_idx: 2'd3, exp_valid: 1'b0};
      vec12[3] = '{word: 12'h800, exp_idx: 2'd0, exp_valid: 1'b1};

      n_rst = 1'b0;
      sclk  = 1'b0;
      mosi  = 1'b0;
      ss8   = 1'b1;
      ss12  = 1'b1;
      ack8  = 1'b0;
      ack12 = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_valid8", 32'(valid8), 32'd0);
      checkOutput("rst_overrun8", 32'(ovr8), 32'd0);
      checkOutput("rst_widx8", 32'(widx8), 32'd0);
      checkOutput("rst_frame8_nonzero", 32'(|f8), 32'd0);
      checkOutput("rst_valid12", 32'(valid12), 32'd0);
      checkOutput("rst_frame12_nonzero", 32'(|f12), 32'd0);
      n_rst = 1'b1;
      repeat (5) @(negedge clk);

      // Aborted frame: five words then three bits of word 5, then deselect
      ss8 = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8, 16'(8'hF0 + i), 1'b0);
      end
      checkOutput("abort_widx_before", 32'(widx8), 32'd5);
      applyStimulus(3, 16'b101, 1'b0);
      ss8 = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("abort_widx", 32'(widx8), 32'd0);
      checkOutput("abort_valid", 32'(valid8), 32'd0);
`ifndef SPI_LOADER_DBUF_EN
      checkOutput("abort_retained_w4", 32'(f8[4]), 32'hF4);
`endif

      // Full frame 0x00..0x7F
      ss8 = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 128; i++) begin
         applyStimulus(8, 16'(i), 1'b0);
         if (i == 126) begin
            checkOutput("frameA_valid_early", 32'(valid8), 32'd0);
         end
      end
      checkOutput("frameA_valid", 32'(valid8), 32'd1);
      checkOutput("frameA_widx_wrap", 32'(widx8), 32'd0);
      checkOutput("frameA_first", 32'(f8[0]), 32'h00);
      checkOutput("frameA_last", 32'(f8[127]), 32'h7F);
      errs = 0;
      for (int i = 0; i < 128; i++) begin
         if (f8[i] !== 8'(i)) errs++;
      end
      checkOutput("frameA_body_errs", 32'(errs), 32'd0);

`ifdef SPI_LOADER_DBUF_EN
      // Second frame, ack arrives mid-frame
      for (int i = 0; i < 128; i++) begin
         applyStimulus(8, 16'(128 + i), 1'b0);
         if (i == 63) begin
            pulseAck8();
            checkOutput("dbuf_ack_valid", 32'(valid8), 32'd0);
            checkOutput("dbuf_ack_frame_kept", 32'(f8[5]), 32'h05);
         end
      end
      checkOutput("dbuf_frameB_valid", 32'(valid8), 32'd1);
      checkOutput("dbuf_frameB_overrun", 32'(ovr8), 32'd0);
      errs = 0;
      for (int i = 0; i < 128; i++) begin
         if (f8[i] !== 8'(128 + i)) errs++;
      end
      checkOutput("dbuf_frameB_body_errs", 32'(errs), 32'd0);

      // Third frame with ack withheld: dropped, overrun
      for (int i = 0; i < 128; i++) begin
         applyStimulus(8, 16'(8'(i) ^ 8'h3C), 1'b0);
      end
      checkOutput("dbuf_frameC_overrun", 32'(ovr8), 32'd1);
      checkOutput("dbuf_frameC_kept_first", 32'(f8[0]), 32'h80);
      checkOutput("dbuf_frameC_kept_last", 32'(f8[127]), 32'hFF);
      checkOutput("dbuf_frameC_valid", 32'(valid8), 32'd1);
      pulseAck8();
      checkOutput("dbuf_final_ack", 32'(valid8), 32'd0);
`else
      // Ack coincides with the next word's completion: word lands at index 0
      applyStimulus(8, 16'h3C, 1'b1);
      checkOutput("samecyc_valid", 32'(valid8), 32'd0);
      checkOutput("samecyc_overrun", 32'(ovr8), 32'd0);
      checkOutput("samecyc_word0", 32'(f8[0]), 32'h3C);
      checkOutput("samecyc_widx", 32'(widx8), 32'd1);
      checkOutput("samecyc_word1_old", 32'(f8[1]), 32'h01);

      for (int i = 1; i < 128; i++) begin
         applyStimulus(8, 16'(128 + i), 1'b0);
      end
      checkOutput("frameB_valid", 32'(valid8), 32'd1);
      checkOutput("frameB_last", 32'(f8[127]), 32'hFF);

      // Extra byte with ack withheld: dropped, overrun
      applyStimulus(8, 16'h55, 1'b0);
      checkOutput("ovr_flag", 32'(ovr8), 32'd1);
      checkOutput("ovr_word0_kept", 32'(f8[0]), 32'h3C);
      checkOutput("ovr_word1_kept", 32'(f8[1]), 32'h81);
      checkOutput("ovr_valid", 32'(valid8), 32'd1);
      checkOutput("ovr_widx", 32'(widx8), 32'd0);

      pulseAck8();
      checkOutput("ack_valid_low", 32'(valid8), 32'd0);
      checkOutput("ack_overrun_sticky", 32'(ovr8), 32'd1);
      pulseAck8();
      checkOutput("ack_ignored_valid", 32'(valid8), 32'd0);
      checkOutput("ack_ignored_widx", 32'(widx8), 32'd0);
`endif

      // Reset asserted mid-stream, away from the clock edge
      applyStimulus(8, 16'h11, 1'b0);
      applyStimulus(8, 16'h22, 1'b0);
      checkOutput("mid_widx", 32'(widx8), 32'd2);
      #3;
      n_rst = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(valid8), 32'd0);
      checkOutput("midrst_overrun", 32'(ovr8), 32'd0);
      checkOutput("midrst_widx", 32'(widx8), 32'd0);
      checkOutput("midrst_frame_nonzero", 32'(|f8), 32'd0);
      ss8 = 1'b1;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("postrst_valid", 32'(valid8), 32'd0);
      checkOutput("postrst_widx", 32'(widx8), 32'd0);

      // 12-bit x 4 instance driven from the vector table
      ss12 = 1'b0;
      repeat (5) @(negedge clk);
      for (int v = 0; v < 4; v++) begin
         applyStimulus(12, 16'(vec12[v].word), 1'b0);
         checkOutput($sformatf("w12_idx_%0d", v), 32'(widx12), 32'(vec12[v].exp_idx));
         checkOutput($sformatf("w12_valid_%0d", v), 32'(valid12), 32'(vec12[v].exp_valid));
      end
      for (int v = 0; v < 4; v++) begin
         checkOutput($sformatf("w12_frame_%0d", v), 32'(f12[v]), 32'(vec12[v].word));
      end
      checkOutput("w12_overrun", 32'(ovr12), 32'd0);
      checkOutput("w12_dut8_idle_widx", 32'(widx8), 32'd0);
      ack12 = 1'b1;
      @(negedge clk);
      ack12 = 1'b0;
      checkOutput("w12_ack_valid", 32'(valid12), 32'd0);
      ss12 = 1'b1;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
Parametrised SPI-slave sample loader for the FFT datapath. Replaces the fixed 8-bit × 128 serial-to-parallel, edge-detect and loading-buffer chain with one block that is generic in sample width and frame depth. Presents a full frame to the FFT core through a valid/ack handshake and reports overruns. Sits between the external SPI pins and the FFT block's loading_buffer input.

Parameters:
DATA_W, 8, bits per sample, MSB first on the wire
NUM_SAMPLES, 128, samples per frame (≥2)
SYNC_STAGES, 2, synchroniser depth for clk_in/ss/data_in (≥2)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
clk_in  input  1  external SPI clock, asynchronous to clk
ss  input  1  slave select, active low, asynchronous
data_in  input  1  SPI serial data, asynchronous
frame_out  output  [0:NUM_SAMPLES-1][DATA_W-1:0]  captured frame; index 0 = first sample received
frame_valid  output  1  frame_out holds a complete frame
frame_ack  input  1  consumer has taken frame_out
overrun  output  1  sticky: a word was dropped because no buffer was free
word_idx  output  clog2(NUM_SAMPLES)  index of next word to be written

Behaviour:
- Reset (n_rst low, async): frame_out all 0, frame_valid 0, overrun 0, word_idx 0, bit counter 0, state IDLE, synchroniser flops 0 (ss flops 1).
- clk_in, ss, data_in each pass through SYNC_STAGES flops; rising edge of synchronised clk_in detected by comparing against one extra delayed flop → one-cycle sclk_rise pulse. Pin-to-capture latency SYNC_STAGES+1 clk cycles. clk must run ≥4× SPI clock.
- States: IDLE (ss high), SHIFT (ss low, collecting), FULL (frame complete, awaiting ack; single-buffer build only).
- IDLE→SHIFT when synchronised ss low. In SHIFT, each sclk_rise shifts synced data_in into the DATA_W shift register LSB; bit counter increments.
- When bit counter reaches DATA_W-1 on sclk_rise: the completed word is written to frame_out[word_idx] in the same cycle; bit counter wraps to 0; word_idx increments.
- Word NUM_SAMPLES-1 written: word_idx wraps to 0; frame_valid asserts the next cycle; state→FULL.
- FULL: frame_out frozen. frame_ack high → frame_valid low next cycle, state→SHIFT (ss low) or IDLE (ss high). Any word completing while in FULL and not acked in that cycle is dropped and overrun set. Ack in the same cycle as a word completion: ack is taken first and the word is written to index 0.
- frame_ack while frame_valid low: ignored.
- ss deasserted mid-word or mid-frame (not FULL): partial word discarded, bit counter 0, word_idx 0, state IDLE; already-written words are retained but will be overwritten. ss deasserted in FULL: frame kept, stays FULL.
- overrun clears only on reset.

Optional Feature:
SPI_LOADER_DBUF_EN: defined → two frame banks (ping-pong). On completion the filled bank becomes frame_out and capture continues into the other bank with no FULL stall. overrun is set only if a second frame completes while frame_valid is still high (that frame is discarded and the capture bank is reused). Undefined → single bank, FULL state as above.

Decomposition:
- Package spi_loader_pkg: state enum (IDLE, SHIFT, FULL), localparams IDX_W = $clog2(NUM_SAMPLES) and BIT_W = $clog2(DATA_W) as functions of parameters, and the frame typedef helper.
- Sub-module sync_edge: SYNC_STAGES synchroniser plus rising-edge pulse, instantiated for clk_in; plain synchronisers (same module, edge output unused) for ss and data_in.

Test Plan:
- Reset: hold n_rst low mid-stream → all outputs 0 immediately; after release with ss high, frame_valid stays 0.
- Defaults, ss low, send bytes 0x00..0x7F MSB first → frame_valid high; frame_out[0]=0x00, frame_out[127]=0x7F; ack → frame_valid low next cycle.
- DATA_W=12, NUM_SAMPLES=4, send 0xABC,0x123,0xFFF,0x800 → frame_out matches in order; word_idx reads 0 after wrap.
- ss high after 3 bits of word 5 → word_idx 0, state IDLE; resend full frame → correct frame, no corruption from the aborted bits.
- Single-buffer: complete a frame, withhold ack, send one more byte → overrun=1, frame_out unchanged; ack in the same cycle as a word completion → no overrun, word written at index 0.
- SPI_LOADER_DBUF_EN: send two back-to-back frames with ack delayed until mid-second frame → no overrun, second frame correct; withhold ack through a third frame → overrun=1.
